// File: rtl/bf_pkg.sv
// Shared encodings for the BF chip byte-serial bus: phase field, bus opcodes
// and the responder state machine.
package bf_pkg;

    typedef enum logic [2:0] {
        IO_NONE       = 3'd0,
        IO_OPCODE     = 3'd1,
        IO_ADDR_HI    = 3'd2,
        IO_ADDR_LO    = 3'd3,
        IO_READ_WRITE = 3'd4
    } io_op_e;

    typedef enum logic [2:0] {
        BUS_NONE       = 3'd0,
        BUS_READ_PROG  = 3'd1,
        BUS_READ_DATA  = 3'd2,
        BUS_WRITE_DATA = 3'd3,
        BUS_INPUT      = 3'd4,
        BUS_OUTPUT     = 3'd5
    } bus_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_HI,
        S_LO,
        S_ACCESS,
        S_DONE
    } resp_state_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == BUS_READ_PROG) || (op == BUS_READ_DATA) || (op == BUS_WRITE_DATA);
    endfunction

endpackage

// File: rtl/bf_bus_responder.sv
// Host-side responder for the BF chip bus: decodes the phase field, collects
// opcode/address/data, performs the memory or stream access and returns data.
module bf_bus_responder
    import bf_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [11:0]           chip_out,
    output logic [11:0]           chip_in,
    input  logic                  run,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_space,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ready,
    input  logic [7:0]            mem_rdata,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic                  chip_halted,
    output logic                  proto_err
);

    resp_state_e           state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  halted_q;
    logic                  mem_req_q, mem_we_q, mem_space_q;
    logic                  in_ready_q, out_valid_q, done_q;

    logic [2:0] phase;
    logic [7:0] bus;

    assign phase = chip_out[10:8];
    assign bus   = chip_out[7:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (phase == IO_OPCODE) begin
                    op_d    = bus[2:0];
                    state_d = S_OP;
                end else if (phase != IO_NONE) begin
                    err_d = 1'b1;
                end
            end
            S_OP: begin
                if (phase == IO_ADDR_HI && !bus[7]) begin
                    addr_d[MEM_ADDR_W-1:8] = bus[MEM_ADDR_W-9:0];
                    state_d                = S_HI;
                end else if (phase != IO_OPCODE) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HI: begin
                if (phase == IO_ADDR_LO) begin
                    addr_d[7:0] = bus;
                    state_d     = S_LO;
                end else if (phase != IO_ADDR_HI) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                if (phase == IO_READ_WRITE) begin
                    wdata_d = bus;
                    state_d = S_ACCESS;
                end else if (phase != IO_ADDR_LO) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            // Strobes are already high throughout ACCESS, so the partner's
            // valid/ready alone completes the handshake.
            S_ACCESS: begin
                case (op_q)
                    BUS_READ_PROG, BUS_READ_DATA: begin
                        if (mem_ready && mem_req_q) begin
                            resp_d  = mem_rdata;
                            state_d = S_DONE;
                        end
                    end
                    BUS_WRITE_DATA: begin
                        if (mem_ready && mem_req_q) begin
                            resp_d  = 8'h00;
                            state_d = S_DONE;
                        end
                    end
                    BUS_INPUT: begin
                        if (in_valid && in_ready_q) begin
                            resp_d  = in_data;
                            state_d = S_DONE;
                        end
                    end
                    BUS_OUTPUT: begin
                        if (out_ready && out_valid_q) begin
                            resp_d  = 8'h00;
                            state_d = S_DONE;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        resp_d  = 8'h00;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                if (run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output strobes are registered decodes of the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_space_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            halted_q    <= chip_out[11];
            mem_req_q   <= (state_d == S_ACCESS) && is_mem_op(op_q);
            mem_we_q    <= (state_d == S_ACCESS) && (op_q == BUS_WRITE_DATA);
            mem_space_q <= (state_d == S_ACCESS) && (op_q == BUS_READ_PROG);
            in_ready_q  <= (state_d == S_ACCESS) && (op_q == BUS_INPUT);
            out_valid_q <= (state_d == S_ACCESS) && (op_q == BUS_OUTPUT);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign chip_in     = {2'b00, run, done_q, resp_q};
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_space   = mem_space_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = wdata_q;
    assign chip_halted = halted_q;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_bf_bus_responder.sv
// Directed bench for bf_bus_responder: table of whole transactions plus
// hand-written error, run-toggling and mid-access reset sequences.
module tb_bf_bus_responder;
    import bf_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] chip_out = '0;
    logic [11:0] chip_in;
    logic        run = 1'b0;
    logic        mem_req, mem_we, mem_space;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_rdata = 8'hEE;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        chip_halted, proto_err;

    bf_bus_responder #(.MEM_ADDR_W(15)) dut (
        .clock(clock), .reset_n(reset_n), .chip_out(chip_out), .chip_in(chip_in),
        .run(run), .mem_req(mem_req), .mem_we(mem_we), .mem_space(mem_space),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .chip_halted(chip_halted), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0, n_fail = 0;
    int mem_xfers = 0, in_xfers = 0, out_xfers = 0, done_takes = 0, req_cycles = 0;
    bit toggle_run = 1'b0;
    logic halted_drv = 1'b0;

    always @(posedge clock) begin
        if (mem_req && mem_ready) mem_xfers++;
        if (in_ready && in_valid) in_xfers++;
        if (out_valid && out_ready) out_xfers++;
        if (chip_in[8] && run) done_takes++;
        if (mem_req) req_cycles++;
    end

    typedef struct {
        logic [2:0]  op;
        logic [14:0] addr;
        logic [7:0]  wdata;
        int          waits;
        logic [7:0]  data;
        int          kind;   // 0 memory, 1 input, 2 output, 3 bad opcode
        logic [7:0]  exp_resp;
        logic        exp_space;
        logic        exp_we;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (toggle_run) run = ~run;
    endtask

    task automatic set_phase(input logic [2:0] p, input logic [7:0] b);
        chip_out = {halted_drv, p, b};
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        chip_out   = '0;
        mem_ready  = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        run        = 1'b0;
        toggle_run = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic send_phases(input vec_t v, input int hold);
        for (int k = 0; k < hold; k++) begin set_phase(IO_OPCODE, {5'b0, v.op}); step(); end
        for (int k = 0; k < hold; k++) begin set_phase(IO_ADDR_HI, {1'b0, v.addr[14:8]}); step(); end
        for (int k = 0; k < hold; k++) begin set_phase(IO_ADDR_LO, v.addr[7:0]); step(); end
        for (int k = 0; k < hold; k++) begin set_phase(IO_READ_WRITE, v.wdata); step(); end
        set_phase(IO_NONE, 8'h00);
    endtask

    task automatic run_txn(input vec_t v, input int hold);
        int m0, i0, o0, d0, cnt;
        logic [2:0] exp_strobe;
        m0 = mem_xfers; i0 = in_xfers; o0 = out_xfers; d0 = done_takes;
        exp_strobe = (v.kind == 0) ? 3'b100 : (v.kind == 1) ? 3'b010 : (v.kind == 2) ? 3'b001 : 3'b000;
        in_data = v.data;
        send_phases(v, hold);
        if (v.kind == 3) begin
            check({v.name, " no strobe"}, {mem_req, in_ready, out_valid}, 3'b000);
            step();
            check({v.name, " done latency"}, chip_in[8], 1'b1);
        end else begin
            cnt = 0;
            while (!chip_in[8] && cnt < 40) begin
                if (cnt == 0) begin
                    check({v.name, " strobe rise"}, {mem_req, in_ready, out_valid}, exp_strobe);
                    if (v.kind == 0) begin
                        check({v.name, " mem_addr"}, mem_addr, v.addr);
                        check({v.name, " mem_space"}, mem_space, v.exp_space);
                        check({v.name, " mem_we"}, mem_we, v.exp_we);
                        if (v.exp_we) check({v.name, " mem_wdata"}, mem_wdata, v.wdata);
                    end
                    if (v.kind == 2) check({v.name, " out_data"}, out_data, v.wdata);
                end
                if (cnt == v.waits) begin
                    check({v.name, " strobe held"}, {mem_req, in_ready, out_valid}, exp_strobe);
                    if (v.kind == 0) begin mem_ready = 1'b1; mem_rdata = v.data; end
                    if (v.kind == 1) in_valid = 1'b1;
                    if (v.kind == 2) out_ready = 1'b1;
                end
                step();
                mem_ready = 1'b0; mem_rdata = 8'hEE; in_valid = 1'b0; out_ready = 1'b0;
                cnt++;
            end
            check({v.name, " done latency"}, cnt, v.waits + 1);
        end
        check({v.name, " op_done"}, chip_in[8], 1'b1);
        check({v.name, " bus_in"}, chip_in[7:0], v.exp_resp);
        check({v.name, " strobe fall"}, {mem_req, in_ready, out_valid}, 3'b000);
        cnt = 0;
        if (!toggle_run) run = 1'b1;
        while (chip_in[8] && cnt < 10) begin step(); cnt++; end
        if (!toggle_run) run = 1'b0;
        check({v.name, " op_done clear"}, chip_in[8], 1'b0);
        check({v.name, " bus_in hold"}, chip_in[7:0], v.exp_resp);
        check({v.name, " done taken once"}, done_takes - d0, 1);
        check({v.name, " mem xfers"}, mem_xfers - m0, (v.kind == 0) ? 1 : 0);
        check({v.name, " in xfers"}, in_xfers - i0, (v.kind == 1) ? 1 : 0);
        check({v.name, " out xfers"}, out_xfers - o0, (v.kind == 2) ? 1 : 0);
        check({v.name, " proto_err"}, proto_err, v.exp_err);
    endtask

    initial begin
        vec_t v;
        int r0;
        vecs[0] = '{BUS_READ_DATA,  15'h1234, 8'h00, 3, 8'hA5, 0, 8'hA5, 1'b0, 1'b0, 1'b0, "rd_data"};
        vecs[1] = '{BUS_WRITE_DATA, 15'h7FFF, 8'h3C, 0, 8'h99, 0, 8'h00, 1'b0, 1'b1, 1'b0, "wr_data"};
        vecs[2] = '{BUS_INPUT,      15'h0000, 8'h00, 5, 8'h41, 1, 8'h41, 1'b0, 1'b0, 1'b0, "input"};
        vecs[3] = '{BUS_READ_PROG,  15'h0ABC, 8'h00, 0, 8'h5A, 0, 8'h5A, 1'b1, 1'b0, 1'b0, "rd_prog"};
        vecs[4] = '{BUS_OUTPUT,     15'h0100, 8'h0A, 2, 8'h00, 2, 8'h00, 1'b0, 1'b0, 1'b0, "output"};
        vecs[5] = '{BUS_READ_DATA,  15'h0001, 8'h00, 1, 8'hFF, 0, 8'hFF, 1'b0, 1'b0, 1'b0, "rd_ff"};
        vecs[6] = '{3'd6,           15'h0002, 8'h00, 0, 8'h00, 3, 8'h00, 1'b0, 1'b0, 1'b1, "bad_op6"};

        do_reset();
        check("reset chip_in", chip_in, 12'h000);
        check("reset strobes", {mem_req, mem_we, mem_space, in_ready, out_valid}, 5'b0);
        check("reset addr/data", {mem_addr, mem_wdata, out_data}, 31'h0);
        check("reset flags", {chip_halted, proto_err}, 2'b00);
        run = 1'b1;
        #1 check("run to enable", chip_in, 12'h200);
        run = 1'b0;

        halted_drv = 1'b1;
        set_phase(IO_NONE, 8'h00);
        step();
        check("halted copy", chip_halted, 1'b1);
        halted_drv = 1'b0;
        set_phase(IO_NONE, 8'h00);
        step();
        check("halted clear", chip_halted, 1'b0);

        foreach (vecs[i]) run_txn(vecs[i], (i == 5) ? 2 : 1);

        // Output with run toggling every cycle and every phase held two cycles.
        do_reset();
        toggle_run = 1'b1;
        v = vecs[4];
        v.name = "output_toggle";
        v.waits = 1;
        run_txn(v, 2);
        toggle_run = 1'b0;
        run = 1'b0;

        // Opcode 7 followed by an illegal AddrHi byte.
        do_reset();
        r0 = req_cycles;
        set_phase(IO_OPCODE, 8'h07); step();
        set_phase(IO_ADDR_HI, 8'h80); step();
        set_phase(IO_NONE, 8'h00);
        check("hi7 proto_err", proto_err, 1'b1);
        step(); step();
        check("hi7 no mem_req", req_cycles - r0, 0);
        check("hi7 no done", chip_in[8], 1'b0);
        v = vecs[0];
        v.name = "after_err";
        v.exp_err = 1'b1;
        run_txn(v, 1);

        do_reset();
        set_phase(IO_ADDR_LO, 8'h12); step();
        set_phase(IO_NONE, 8'h00);
        check("addrlo in idle", proto_err, 1'b1);

        do_reset();
        set_phase(IO_OPCODE, 8'h02); step();
        set_phase(IO_ADDR_HI, 8'h12); step();
        set_phase(IO_NONE, 8'h00); step();
        check("none in hi", proto_err, 1'b1);

        // Reset asserted while a read is waiting on memory.
        do_reset();
        send_phases(vecs[0], 1);
        step(); step();
        check("pre-reset mem_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async drop mem_req", mem_req, 1'b0);
        check("async drop chip_in", chip_in, 12'h000);
        #3 reset_n = 1'b1;
        v = vecs[3];
        v.name = "after_reset";
        run_txn(v, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
